// File: rtl/mips_wb_pkg.sv
// Shared write-back types and constants for the MIPS register-file write port.
package mips_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back request channels (ALU and load), each a valid/ready handshake carrying {reg, data}.
interface regfile_wb_ctrl_if #(
    parameter int ADDR_W = mips_wb_pkg::REG_ADDR_W,
    parameter int DATA_W = mips_wb_pkg::DATA_W
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_reg;
    logic [DATA_W-1:0] ld_data;

    modport master (
        output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        input  alu_ready, ld_ready
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        output alu_ready, ld_ready
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order write-back FIFO; exposes every entry oldest-first for the pending-write scoreboard.
// Entry data taps are only built when WB_BYPASS_EN is defined.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        pushReg,
    input  logic [DATA_W-1:0]        pushData,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        headReg,
    output logic [DATA_W-1:0]        headData,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         tagValid,
    output logic [ADDR_W-1:0]        tagReg [DEPTH],
`ifdef WB_BYPASS_EN
    output logic [DATA_W-1:0]        tagData [DEPTH],
`endif
    output logic                     full
);
    import mips_wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    assign full     = (count == CNT_W'(DEPTH));
    assign headReg  = regMem[rdPtr];
    assign headData = dataMem[rdPtr];

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            regMem[wrPtr]  <= pushReg;
            dataMem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag i is the i-th oldest entry, so index 0 is the next to drain.
    for (genvar i = 0; i < DEPTH; i++) begin : g_tag
        logic [PTR_W-1:0] idx;
        assign idx         = rdPtr + PTR_W'(i);
        assign tagValid[i] = (CNT_W'(i) < count);
        assign tagReg[i]   = regMem[idx];
`ifdef WB_BYPASS_EN
        assign tagData[i]  = dataMem[idx];
`endif
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: load/ALU arbiter, in-order FIFO, registered write port,
// RAW scoreboard and, when WB_BYPASS_EN is defined, youngest-match forwarding of pending data.
module regfile_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = mips_wb_pkg::DATA_W,
    parameter int ADDR_W = mips_wb_pkg::REG_ADDR_W
) (
    input  logic                   clock,
    input  logic                   reset_n,
    regfile_wb_ctrl_if.slave       wbIf,
    input  logic [ADDR_W-1:0]      query_reg,
    output logic                   query_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   byp_hit,
    output logic [DATA_W-1:0]      byp_data,
    output logic [ADDR_W-1:0]      WriteRegister,
    output logic [DATA_W-1:0]      WriteData_reg,
    output logic                   RegWrite
);
    import mips_wb_pkg::*;

    logic              full;
    logic              ldTake;
    logic              aluTake;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pushReg;
    logic [DATA_W-1:0] pushData;
    logic [ADDR_W-1:0] headReg;
    logic [DATA_W-1:0] headData;
    logic [DEPTH-1:0]  tagValid;
    logic [ADDR_W-1:0] tagReg [DEPTH];
`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] tagData [DEPTH];
`endif

    // Readies ignore a same-cycle drain when full: simpler timing, one cycle of lost throughput.
    assign wbIf.ld_ready  = !full;
    assign wbIf.alu_ready = !full && !wbIf.ld_valid;

    assign ldTake   = wbIf.ld_valid && !full;
    assign aluTake  = wbIf.alu_valid && !wbIf.ld_valid && !full;
    assign pushReg  = ldTake ? wbIf.ld_reg  : wbIf.alu_reg;
    assign pushData = ldTake ? wbIf.ld_data : wbIf.alu_data;
    assign push     = (ldTake || aluTake) && (pushReg != REG_ZERO);
    assign pop      = (fifo_count != '0);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .pushReg  (pushReg),
        .pushData (pushData),
        .pop      (pop),
        .headReg  (headReg),
        .headData (headData),
        .count    (fifo_count),
        .tagValid (tagValid),
        .tagReg   (tagReg),
`ifdef WB_BYPASS_EN
        .tagData  (tagData),
`endif
        .full     (full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData_reg <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                WriteRegister <= headReg;
                WriteData_reg <= headData;
            end
        end
    end

    always_comb begin
        logic hit;
        hit = RegWrite && (WriteRegister == query_reg);
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit || (tagValid[i] && (tagReg[i] == query_reg));
        end
        query_busy = hit && (query_reg != REG_ZERO);
    end

`ifdef WB_BYPASS_EN
    // Search oldest to youngest so the last match (youngest) wins.
    always_comb begin
        byp_hit  = query_busy;
        byp_data = '0;
        if (RegWrite && (WriteRegister == query_reg)) byp_data = WriteData_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (tagValid[i] && (tagReg[i] == query_reg)) byp_data = tagData[i];
        end
        if (!query_busy) byp_data = '0;
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
`endif

endmodule
